// File: rtl/project1_buttons_ctrl_if.sv
// rtl/project1_buttons_ctrl_if.sv - register bus between the CPU interconnect and the button controller
interface project1_buttons_ctrl_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/project1_buttons_ctrl.sv
// rtl/project1_buttons_ctrl.sv - push-button debounce, edge capture and interrupt controller
module project1_buttons_ctrl #(
  parameter int WIDTH           = 3,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  project1_buttons_ctrl_if.slave  bus,
  input  logic [WIDTH-1:0]        in_port,
  output logic                    irq
);

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_CHANGING = 1'b1
  } deb_state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;

  deb_state_t       state_q [WIDTH];
  deb_state_t       state_d [WIDTH];
  logic [CNT_W-1:0] cnt_q   [WIDTH];
  logic [CNT_W-1:0] cnt_d   [WIDTH];
  logic [WIDTH-1:0] deb_q;
  logic [WIDTH-1:0] deb_d;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] edge_sel;

  logic [WIDTH-1:0] irqmask_q;
  logic [WIDTH-1:0] edgecap_q;
  logic [WIDTH-1:0] pol_q;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] cap_clr;
  logic [WIDTH-1:0] rd_sel;
  logic             wr_en;

  // Upper write-data bits carry no register state.
  logic unused_wdata;
  assign unused_wdata = &{1'b0, bus.writedata[31:WIDTH]};

  assign wdata = bus.writedata[WIDTH-1:0];
  assign wr_en = bus.chipselect && !bus.write_n;

  // Two-flop synchronizer for the asynchronous button pins.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync1_q;
    end
  end

  // Per-button debounce next-state: a new level must hold DEBOUNCE_CYCLES clocks.
  always_comb begin
    deb_d    = deb_q;
    edge_det = '0;
    for (int i = 0; i < WIDTH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_STABLE: begin
          if (sync2_q[i] != deb_q[i]) begin
            state_d[i] = ST_CHANGING;
            cnt_d[i]   = '0;
          end
        end
        ST_CHANGING: begin
          if (sync2_q[i] == deb_q[i]) begin
            state_d[i] = ST_STABLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_MAX) begin
            state_d[i]  = ST_STABLE;
            deb_d[i]    = sync2_q[i];
            edge_det[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        default: begin
          state_d[i] = ST_STABLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Debounce state, counters and accepted levels.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= ST_STABLE;
        cnt_q[i]   <= '0;
      end
      deb_q <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      deb_q <= deb_d;
    end
  end

  // The new level equals pol only on the selected edge direction.
  assign edge_sel = edge_det & ~(deb_d ^ pol_q);
  assign cap_clr  = (wr_en && bus.address == 2'd2) ? wdata : '0;

  // Register writes; a capture in the same cycle as its clear keeps the bit set.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irqmask_q <= '0;
      edgecap_q <= '0;
      pol_q     <= '0;
    end else begin
      if (wr_en && bus.address == 2'd1) irqmask_q <= wdata;
      if (wr_en && bus.address == 2'd3) pol_q     <= wdata;
      edgecap_q <= (edgecap_q & ~cap_clr) | edge_sel;
    end
  end

  // Read mux, independent of chipselect.
  always_comb begin
    rd_sel = '0;
    case (bus.address)
      2'd0:    rd_sel = deb_q;
      2'd1:    rd_sel = irqmask_q;
      2'd2:    rd_sel = edgecap_q;
      2'd3:    rd_sel = pol_q;
      default: rd_sel = '0;
    endcase
  end

  // Registered read data and level interrupt.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus.readdata <= '0;
      irq          <= 1'b0;
    end else begin
      bus.readdata <= {{(32-WIDTH){1'b0}}, rd_sel};
      irq          <= |(edgecap_q & irqmask_q);
    end
  end

endmodule

// File: tb/tb_project1_buttons_ctrl.sv
// tb/tb_project1_buttons_ctrl.sv - directed self-checking bench for project1_buttons_ctrl
module tb_project1_buttons_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] in_port;
  logic       irq;
  int         n_cmp  = 0;
  int         n_fail = 0;

  project1_buttons_ctrl_if bus_if ();

  project1_buttons_ctrl #(
    .WIDTH(3),
    .DEBOUNCE_CYCLES(4),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus_if),
    .in_port(in_port),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] addr, input logic [31:0] data);
    bus_if.address    = addr;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    bus_if.writedata  = data;
    tick();
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.writedata  = '0;
  endtask

  task automatic rd(input logic [1:0] addr, input logic [31:0] exp, input string tag);
    bus_if.address = addr;
    tick();
    check(tag, bus_if.readdata, exp);
  endtask

  initial begin
    reset_n           = 1'b0;
    in_port           = 3'b000;
    bus_if.address    = 2'd0;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.writedata  = '0;
    tick(2);
    check("reset_readdata", bus_if.readdata, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    reset_n = 1'b1;

    rd(2'd0, 32'h0, "t1_data");
    rd(2'd1, 32'h0, "t1_irqmask");
    rd(2'd2, 32'h0, "t1_edgecap");
    rd(2'd3, 32'h0, "t1_polarity");
    check("t1_irq", {31'b0, irq}, 32'h0);

    bus_if.address = 2'd0;
    in_port = 3'b001;
    tick(3);
    in_port = 3'b000;
    tick(10);
    check("t2_glitch_data", bus_if.readdata, 32'h0);
    rd(2'd2, 32'h0, "t2_glitch_edgecap");

    wr(2'd3, 32'h2);
    wr(2'd1, 32'h2);
    bus_if.address = 2'd0;
    in_port = 3'b010;
    tick(7);
    check("t3_data_before", bus_if.readdata, 32'h0);
    check("t3_irq_before", {31'b0, irq}, 32'h0);
    tick();
    check("t3_data_after", bus_if.readdata, 32'h2);
    check("t3_irq_after", {31'b0, irq}, 32'h1);
    rd(2'd2, 32'h2, "t3_edgecap");

    wr(2'd2, 32'h2);
    check("t4_rd_in_clear_cycle", bus_if.readdata, 32'h2);
    check("t4_irq_in_clear_cycle", {31'b0, irq}, 32'h1);
    tick();
    check("t4_edgecap_cleared", bus_if.readdata, 32'h0);
    check("t4_irq_cleared", {31'b0, irq}, 32'h0);

    wr(2'd3, 32'h0);
    in_port = 3'b000;
    tick(6);
    wr(2'd2, 32'h2);
    check("t4_collision_rd_old", bus_if.readdata, 32'h0);
    tick();
    check("t4_collision_edgecap", bus_if.readdata, 32'h2);
    check("t4_collision_irq", {31'b0, irq}, 32'h1);
    rd(2'd0, 32'h0, "t4_data_fell");
    wr(2'd2, 32'h2);
    tick();
    check("t4_reclear", bus_if.readdata, 32'h0);

    bus_if.address = 2'd0;
    in_port = 3'b100;
    tick(3);
    reset_n = 1'b0;
    tick();
    check("t5_reset_readdata", bus_if.readdata, 32'h0);
    check("t5_reset_irq", {31'b0, irq}, 32'h0);
    reset_n = 1'b1;
    rd(2'd1, 32'h0, "t5_irqmask");
    rd(2'd2, 32'h0, "t5_edgecap");
    rd(2'd3, 32'h0, "t5_polarity");
    bus_if.address = 2'd0;
    tick(4);
    check("t5_data_before", bus_if.readdata, 32'h0);
    tick();
    check("t5_data_after", bus_if.readdata, 32'h4);
    rd(2'd2, 32'h0, "t5_no_rise_capture");
    check("t5_irq", {31'b0, irq}, 32'h0);

    wr(2'd1, 32'hFFFF_FFFF);
    wr(2'd3, 32'hFFFF_FFFF);
    rd(2'd1, 32'h7, "t6_irqmask");
    rd(2'd3, 32'h7, "t6_polarity");
    wr(2'd0, 32'hFFFF_FFFF);
    tick();
    check("t6_data_ro", bus_if.readdata, 32'h4);
    check("t6_irq", {31'b0, irq}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
